// File: rtl/dds_lut_scheduler.sv
// rtl/dds_lut_scheduler.sv - multi-channel DDS phase accumulators sharing one registered waveform LUT
// Channels are serviced lowest-index first, three cycles each: ADDR, WAIT (ROM latency), CAPTURE.
module dds_lut_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sample_tick,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH*PHASE_W-1:0] tuning_word,
    output logic [ADDR_W-1:0]         lut_addr,
    input  logic [DATA_W-1:0]         lut_data,
    output logic [NUM_CH*DATA_W-1:0]  sample_out,
    output logic [NUM_CH-1:0]         sample_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_CAPTURE} state_t;

    state_t                     state_q, state_d;
    logic [NUM_CH-1:0]          pending_q, pending_d;
    logic [NUM_CH-1:0]          pending_left;
    logic [CH_W-1:0]            cur_q, first_idx;
    logic [PHASE_W-1:0]         phase_q [NUM_CH];
    logic [ADDR_W-1:0]          lut_addr_q;
    logic [NUM_CH*DATA_W-1:0]   sample_out_q;
    logic [NUM_CH-1:0]          sample_valid_q;
    logic                       overrun_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) first_idx = CH_W'(i);
        end
    end

    assign pending_left = pending_q & ~(NUM_CH'(1) << cur_q);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    pending_d = ch_enable;
                    if (ch_enable != '0) state_d = S_ADDR;
                end
            end
            S_ADDR:  state_d = S_WAIT;
            S_WAIT:  state_d = S_CAPTURE;
            S_CAPTURE: begin
                pending_d = pending_left;
                state_d   = (pending_left != '0) ? S_ADDR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Phases of disabled channels are zeroed only while idle so a running frame is never disturbed.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) phase_q[i] <= '0;
            cur_q          <= '0;
            lut_addr_q     <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= '0;
            overrun_q      <= 1'b0;
        end else begin
            sample_valid_q <= '0;
            if (busy && sample_tick) overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (!ch_enable[i]) phase_q[i] <= '0;
                    end
                end
                S_ADDR: begin
                    cur_q      <= first_idx;
                    lut_addr_q <= phase_q[first_idx][PHASE_W-1 -: ADDR_W];
                end
                S_CAPTURE: begin
                    sample_out_q[cur_q*DATA_W +: DATA_W] <= lut_data;
                    sample_valid_q[cur_q]                <= 1'b1;
                    phase_q[cur_q] <= phase_q[cur_q] + tuning_word[cur_q*PHASE_W +: PHASE_W];
                end
                default: ;
            endcase
        end
    end

    assign lut_addr     = lut_addr_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_dds_lut_scheduler.sv
// tb/tb_dds_lut_scheduler.sv - directed self-checking bench for dds_lut_scheduler
// The LUT is modelled as a 1-cycle registered ROM with rom[a] = a << 6.
module tb_dds_lut_scheduler;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sample_tick = 1'b0;
    logic [3:0]    ch_enable = '0;
    logic [127:0]  tuning_word = '0;
    logic [9:0]    lut_addr;
    logic [15:0]   lut_data = '0;
    logic [63:0]   sample_out;
    logic [3:0]    sample_valid;
    logic          busy;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    int          tick2_j, tick3_j, chg_j, rst_j;
    logic [3:0]  chg_en;
    int          nvalid, busy_cnt, multi;
    int          v_j   [16];
    int          v_ch  [16];
    logic [15:0] v_val [16];
    logic [9:0]  addr1;

    dds_lut_scheduler #(
        .NUM_CH(4), .PHASE_W(32), .ADDR_W(10), .DATA_W(16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .ch_enable    (ch_enable),
        .tuning_word  (tuning_word),
        .lut_addr     (lut_addr),
        .lut_data     (lut_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) lut_data <= {lut_addr, 6'b0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        sample_tick = 1'b0;
        ch_enable   = '0;
        tuning_word = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // j counts edges after the tick edge; observations are taken on the falling edge following edge j.
    task automatic run_frame(input logic [3:0] en, input int ncyc);
        nvalid = 0; busy_cnt = 0; multi = 0; addr1 = '0;
        for (int k = 0; k < 16; k++) begin
            v_j[k] = -1; v_ch[k] = -1; v_val[k] = '0;
        end
        @(negedge clock);
        ch_enable   = en;
        sample_tick = 1'b1;
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clock);
            sample_tick = 1'b0;
            reset       = 1'b0;
            if (busy) busy_cnt++;
            if (j == 1) addr1 = lut_addr;
            if ($countones(sample_valid) > 1) multi++;
            for (int c = 0; c < 4; c++) begin
                if (sample_valid[c] && nvalid < 16) begin
                    v_j[nvalid]   = j;
                    v_ch[nvalid]  = c;
                    v_val[nvalid] = sample_out[c*16 +: 16];
                    nvalid++;
                end
            end
            if (j + 1 == tick2_j || j + 1 == tick3_j) sample_tick = 1'b1;
            if (j == chg_j) ch_enable = chg_en;
            if (j + 1 == rst_j) reset = 1'b1;
        end
        tick2_j = -1; tick3_j = -1; chg_j = -1; rst_j = -1;
    endtask

    task automatic check_pulse(input string tag, input int idx, input int j, input int ch,
                               input logic [15:0] val);
        check_eq({tag, "_cyc"}, 64'(v_j[idx]), 64'(j));
        check_eq({tag, "_ch"},  64'(v_ch[idx]), 64'(ch));
        check_eq({tag, "_val"}, 64'(v_val[idx]), 64'(val));
    endtask

    initial begin
        tick2_j = -1; tick3_j = -1; chg_j = -1; rst_j = -1; chg_en = '0;

        // reset state
        do_reset();
        check_eq("rst_addr",    64'(lut_addr), 64'h0);
        check_eq("rst_out",     sample_out, 64'h0);
        check_eq("rst_valid",   64'(sample_valid), 64'h0);
        check_eq("rst_busy",    64'(busy), 64'h0);
        check_eq("rst_overrun", 64'(overrun), 64'h0);

        // single channel, four ticks spaced 8 cycles
        tuning_word[0 +: 32] = 32'h0040_0000;
        for (int f = 0; f < 4; f++) begin
            run_frame(4'b0001, 7);
            check_eq($sformatf("single%0d_n", f), 64'(nvalid), 64'd1);
            check_pulse($sformatf("single%0d", f), 0, 3, 0, 16'(f * 16'h40));
            check_eq($sformatf("single%0d_busy", f), 64'(busy_cnt), 64'd3);
        end

        // round-robin over 1011
        do_reset();
        tuning_word[0 +: 32]  = 32'h0040_0000;
        tuning_word[32 +: 32] = 32'h0080_0000;
        tuning_word[64 +: 32] = 32'h1234_5678;
        tuning_word[96 +: 32] = 32'h0100_0000;
        run_frame(4'b1011, 11);
        check_eq("rr1_n", 64'(nvalid), 64'd3);
        check_pulse("rr1_a", 0, 3, 0, 16'h0000);
        check_pulse("rr1_b", 1, 6, 1, 16'h0000);
        check_pulse("rr1_c", 2, 9, 3, 16'h0000);
        check_eq("rr1_busy",  64'(busy_cnt), 64'd9);
        check_eq("rr1_multi", 64'(multi), 64'd0);
        run_frame(4'b1011, 11);
        check_eq("rr2_n", 64'(nvalid), 64'd3);
        check_pulse("rr2_a", 0, 3, 0, 16'h0040);
        check_pulse("rr2_b", 1, 6, 1, 16'h0080);
        check_pulse("rr2_c", 2, 9, 3, 16'h0100);
        check_eq("rr2_busy", 64'(busy_cnt), 64'd9);
        check_eq("rr2_out2", 64'(sample_out[32 +: 16]), 64'h0);

        // phase wrap-around
        do_reset();
        tuning_word[0 +: 32] = 32'h8000_0000;
        run_frame(4'b0001, 7);
        check_eq("wrap0_addr", 64'(addr1), 64'd0);
        check_eq("wrap0_val",  64'(v_val[0]), 64'h0000);
        run_frame(4'b0001, 7);
        check_eq("wrap1_addr", 64'(addr1), 64'd512);
        check_eq("wrap1_val",  64'(v_val[0]), 64'h8000);
        run_frame(4'b0001, 7);
        check_eq("wrap2_addr", 64'(addr1), 64'd0);
        check_eq("wrap2_val",  64'(v_val[0]), 64'h0000);

        // overrun: late ticks at edge 5 and on the final CAPTURE edge 12
        do_reset();
        tick2_j = 5;
        tick3_j = 12;
        run_frame(4'b1111, 16);
        check_eq("ovr_n",       64'(nvalid), 64'd4);
        check_eq("ovr_busy",    64'(busy_cnt), 64'd12);
        check_eq("ovr_last",    64'(v_j[3]), 64'd12);
        check_eq("ovr_flag",    64'(overrun), 64'd1);
        run_frame(4'b0001, 7);
        check_eq("ovr_hold",    64'(overrun), 64'd1);
        do_reset();
        check_eq("ovr_cleared", 64'(overrun), 64'd0);

        // mid-frame enable change
        tuning_word[0 +: 32]  = 32'h0040_0000;
        tuning_word[32 +: 32] = 32'h0080_0000;
        chg_j  = 3;
        chg_en = 4'b0001;
        run_frame(4'b0011, 9);
        check_eq("mid1_n", 64'(nvalid), 64'd2);
        check_pulse("mid1_b", 1, 6, 1, 16'h0000);
        check_eq("mid1_busy", 64'(busy_cnt), 64'd6);
        run_frame(4'b0001, 7);
        check_eq("mid2_n", 64'(nvalid), 64'd1);
        check_pulse("mid2_a", 0, 3, 0, 16'h0040);
        run_frame(4'b0011, 9);
        check_pulse("mid3_a", 0, 3, 0, 16'h0080);
        check_pulse("mid3_b", 1, 6, 1, 16'h0000);

        // reset asserted during WAIT of ch1
        do_reset();
        tuning_word[0 +: 32]  = 32'h0040_0000;
        tuning_word[32 +: 32] = 32'h0080_0000;
        run_frame(4'b0011, 9);
        rst_j = 5;
        run_frame(4'b0011, 12);
        check_eq("rstmid_n", 64'(nvalid), 64'd1);
        check_pulse("rstmid_a", 0, 3, 0, 16'h0040);
        check_eq("rstmid_out",  sample_out, 64'h0);
        check_eq("rstmid_addr", 64'(lut_addr), 64'h0);
        check_eq("rstmid_busy", 64'(busy), 64'h0);
        run_frame(4'b0011, 9);
        check_eq("rstnext_n", 64'(nvalid), 64'd2);
        check_pulse("rstnext_a", 0, 3, 0, 16'h0000);
        check_pulse("rstnext_b", 1, 6, 1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_lut_scheduler.md
DDS_LUT_SCHEDULER -- requirements
Module: dds_lut_scheduler

Interface
- REQ-001 Parameters (name, default, meaning), one per line:
  - NUM_CH, 4, number of DDS channels sharing one waveform LUT read port
  - PHASE_W, 32, phase accumulator width
  - ADDR_W, 10, LUT address width
  - DATA_W, 16, LUT sample width
- REQ-002 Ports (name, direction, width, meaning), one per line:
  - clock, in, 1, single clock; all logic on its rising edge
  - reset, in, 1, synchronous, active-high reset
  - sample_tick, in, 1, one-cycle strobe that starts a sample frame
  - ch_enable, in, NUM_CH, per-channel enable
  - tuning_word, in, NUM_CH*PHASE_W, per-channel phase increment; channel i at bits [i*PHASE_W +: PHASE_W]
  - lut_addr, out, ADDR_W, registered address to the shared LUT
  - lut_data, in, DATA_W, LUT output; valid on the edge after lut_addr is sampled (1-cycle registered ROM)
  - sample_out, out, NUM_CH*DATA_W, latest sample per channel
  - sample_valid, out, NUM_CH, one-cycle pulse per updated channel
  - busy, out, 1, high whenever the state is not IDLE
  - overrun, out, 1, sticky flag: a tick arrived while busy

Function
- REQ-003 The FSM SHALL have states IDLE, ADDR, WAIT and CAPTURE; busy SHALL equal (state != IDLE).
- REQ-004 In IDLE, an edge with sample_tick=1 SHALL latch pending=ch_enable.
  - If pending != 0, go to ADDR; otherwise stay in IDLE and pulse no sample_valid.
- REQ-005 In ADDR, the scheduler SHALL select cur = lowest-indexed set bit of pending, load lut_addr <= phase[cur][PHASE_W-1 -: ADDR_W], and go to WAIT.
- REQ-006 WAIT SHALL last exactly one cycle, then go to CAPTURE; lut_addr SHALL hold its value.
- REQ-007 On the CAPTURE edge the block SHALL, in the same edge:
  - load sample_out[cur] <= lut_data and sample_valid[cur] <= 1 for exactly one cycle;
  - load phase[cur] <= phase[cur] + tuning_word[cur], modulo 2^PHASE_W (wrap, no saturation), using the tuning_word present on that edge;
  - clear pending[cur].
- REQ-008 After CAPTURE, the FSM SHALL go to ADDR if pending is still nonzero after clearing cur, else to IDLE.
- REQ-009 Latency SHALL be fixed:
  - the first sample_valid is visible 3 cycles after the tick edge;
  - each further channel adds 3 cycles;
  - a frame of k enabled channels keeps busy high for exactly 3k cycles.
- REQ-010 The pending mask SHALL be frozen for the frame: ch_enable changes mid-frame neither add nor drop channels until the next tick.
- REQ-011 In IDLE, phase[i] SHALL be cleared to 0 on every edge where ch_enable[i]=0; phases SHALL never be cleared while busy.
- REQ-012 sample_tick=1 on any edge where busy=1 SHALL be ignored and SHALL set overrun=1.
  - This includes the final CAPTURE cycle of a frame.
  - overrun SHALL clear only on reset.
- REQ-013 sample_out[i] for unserviced channels SHALL hold its previous value; at most one sample_valid bit SHALL be high in any cycle.

Reset
- REQ-014 With reset=1 on an edge, the block SHALL set: state=IDLE, pending=0, every phase=0, lut_addr=0, sample_out=0, sample_valid=0, overrun=0.
- REQ-015 Reset SHALL take priority over every other input, including mid-frame; no sample_valid pulse SHALL follow a frame aborted by reset.

Verification
- REQ-016 The bench SHALL model the LUT as a 1-cycle registered ROM with rom[a] = a<<6 and SHALL cover these scenarios:
  - Single channel: ch_enable=0001, tuning_word0=0x0040_0000, four ticks spaced 8 cycles apart -> sample_out0 = 0x0000, 0x0040, 0x0080, 0x00C0; each sample_valid[0] pulse 3 cycles after its tick; busy high 3 cycles per frame.
  - Round-robin: ch_enable=1011, all phases 0, tuning words 0x0040_0000/0x0080_0000/-/0x0100_0000, two ticks -> first frame valid order ch0, ch1, ch3 at +3/+6/+9 cycles, values all 0; second frame values 0x0040, 0x0080, 0x0100; busy 9 cycles per frame.
  - Wrap-around: tuning_word0=0x8000_0000, three ticks -> addresses 0, 512, 0; sample_out0 = 0x0000, 0x8000, 0x0000.
  - Overrun: ch_enable=1111, second tick 5 cycles after the first, and a third tick on the final CAPTURE cycle -> both late ticks ignored; exactly 4 valid pulses; overrun=1 and held until reset.
  - Mid-frame changes: ch_enable 0011 -> 0001 after ch0's capture -> ch1 still serviced this frame; on the next idle cycle phase1 clears to 0, and the next frame services ch0 only.
  - Reset mid-frame: reset asserted in WAIT of ch1 -> no further sample_valid; all outputs 0; the next tick restarts with phases at 0.
